// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer arbiter.
package fb_pkg;

  localparam int FB_W       = 160;
  localparam int FB_H       = 210;
  localparam int FB_SIZE    = FB_W * FB_H;
  localparam int PIX_W      = 7;
  localparam int ADDR_W     = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int LVL_W      = PTR_W + 1;

  // Who owns the BRAM port in a given cycle.
  typedef enum logic [1:0] {
    G_IDLE  = 2'd0,
    G_READ  = 2'd1,
    G_WRITE = 2'd2
  } grant_e;

  // One buffered pixel write.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [PIX_W-1:0]  data;
  } fb_entry_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// Small synchronous FIFO holding pixel writes until the BRAM port is free.
// The level is a separate counter so full/empty need no pointer tricks.
module fb_wr_fifo
  import fb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  fb_entry_t        push_entry,
  input  logic             pop,
  output fb_entry_t        head,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  fb_entry_t        mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage array; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  // Pointers wrap naturally; level tracks push/pop, unchanged when both occur.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign full  = (level == LVL_W'(FIFO_DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer port arbiter: scan-out reads always win, TIA pixel writes are
// queued and drained into cycles without a read. No read/write forwarding.
//
// Writer handshake: a pixel transfers on a clk edge where wr_valid and
// wr_ready are both high; wr_ready depends only on the registered FIFO level
// (and is low while reset is held), never on the same-cycle pop.
module fb_arbiter
  import fb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [PIX_W-1:0]  vid_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata,
  output logic [2:0]        fifo_level,
  output logic              oob_err
);

  grant_e            grant;
  grant_e            grant_q;
  logic [ADDR_W-1:0] last_addr;
  logic              fresh;
  logic              rd_req;
  logic              rd2;
  logic              accept;
  logic              in_range;
  logic              push;
  logic              pop;
  fb_entry_t         head;
  logic              full;
  logic              empty;

  // A read is wanted when the scan-out address moves, and always right after reset.
  assign rd_req   = fresh || (vid_addr != last_addr);

  assign wr_ready = reset && !full;
  assign accept   = wr_valid && wr_ready;
  assign in_range = (wr_addr < ADDR_W'(FB_SIZE));
  assign push     = accept && in_range;
  assign pop      = (grant == G_WRITE);

  fb_wr_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry ('{addr: wr_addr, data: wr_data}),
    .pop        (pop),
    .head       (head),
    .level      (fifo_level),
    .full       (full),
    .empty      (empty)
  );

  // Next grant: read first, then a queued write, otherwise idle.
  always_comb begin
    grant = G_IDLE;
    if (rd_req) begin
      grant = G_READ;
    end else if (!empty) begin
      grant = G_WRITE;
    end
  end

  // Grant register and the BRAM command it drives.
  always_ff @(posedge clk) begin
    if (!reset) begin
      grant_q   <= G_IDLE;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      grant_q <= grant;
      case (grant)
        G_READ: begin
          ram_addr <= vid_addr;
        end
        G_WRITE: begin
          ram_addr  <= head.addr;
          ram_wdata <= head.data;
        end
        default: begin
          ram_addr <= ram_addr;
        end
      endcase
    end
  end

  assign ram_we = (grant_q == G_WRITE);

  // Read detect and read-data pipeline; grant_q==G_READ is the first stage.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_addr <= '1;
      fresh     <= 1'b1;
      rd2       <= 1'b0;
      vid_data  <= '0;
    end else begin
      fresh <= 1'b0;
      if (rd_req) last_addr <= vid_addr;
      rd2 <= (grant_q == G_READ);
      if (rd2) vid_data <= ram_rdata;
    end
  end

  // Sticky flag for writes discarded by the range check.
  always_ff @(posedge clk) begin
    if (!reset) begin
      oob_err <= 1'b0;
    end else if (accept && !in_range) begin
      oob_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter with a behavioural BRAM.
module tb_fb_arbiter;
  import fb_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [PIX_W-1:0]  wr_data = '0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic              wr_ready;
  logic [PIX_W-1:0]  vid_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [PIX_W-1:0]  ram_wdata;
  logic [PIX_W-1:0]  ram_rdata = '0;
  logic [2:0]        fifo_level;
  logic              oob_err;

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  fb_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .vid_addr   (vid_addr),
    .vid_data   (vid_data),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .fifo_level (fifo_level),
    .oob_err    (oob_err)
  );

  // Behavioural BRAM (read-first, 1-cycle latency) and the bench's own image of it.
  logic [PIX_W-1:0] mem     [65536];
  logic [PIX_W-1:0] ref_mem [65536];

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = PIX_W'($urandom);
      ref_mem[i] = mem[i];
    end
    mem[0]     = 7'h55;
    ref_mem[0] = 7'h55;
  end

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // ---------------- checking helpers ----------------
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle, act, exp);
    end
  endtask

  // ---------------- scoreboard: BRAM write order ----------------
  logic [ADDR_W+PIX_W-1:0] exp_q[$];
  logic [ADDR_W+PIX_W-1:0] mon_e;

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL ram_write_unexpected cycle=%0d got addr=%0d data=%0h expected no write",
                 cycle, ram_addr, ram_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("ram_write", 32'({ram_addr, ram_wdata}), 32'(mon_e));
        ref_mem[mon_e[ADDR_W+PIX_W-1:PIX_W]] = mon_e[PIX_W-1:0];
      end
    end
  end

  // ---------------- reference model: slots, levels, read latency ----------------
  bit                started = 1'b0;
  bit                m_fresh;
  bit                m_oob;
  bit                exp_we;
  bit                m_req;
  int                m_level;
  logic [ADDR_W-1:0] m_last;
  logic [ADDR_W-1:0] m_a;
  logic [PIX_W-1:0]  exp_vid;
  int                cap_cyc[$];
  logic [ADDR_W-1:0] cap_addr[$];
  int                app_cyc[$];
  logic [PIX_W-1:0]  app_val[$];

  always @(negedge clk) begin
    #1;
    if (started) begin
      check("ram_we", 32'(ram_we), 32'(exp_we));
      if (cap_cyc.size() > 0 && cap_cyc[0] == cycle) begin
        void'(cap_cyc.pop_front());
        m_a = cap_addr.pop_front();
        check("read_addr", 32'(ram_addr), 32'(m_a));
        app_cyc.push_back(cycle + 2);
        app_val.push_back(ref_mem[m_a]);
      end
      if (app_cyc.size() > 0 && app_cyc[0] == cycle) begin
        void'(app_cyc.pop_front());
        exp_vid = app_val.pop_front();
      end
      check("vid_data", 32'(vid_data), 32'(exp_vid));
      check("fifo_level", 32'(fifo_level), 32'(m_level));
      check("wr_ready", 32'(wr_ready), 32'(reset && (m_level < FIFO_DEPTH)));
      check("oob_err", 32'(oob_err), 32'(m_oob));
    end
    if (!reset) begin
      started = 1'b1;
      m_fresh = 1'b1;
      m_oob   = 1'b0;
      exp_we  = 1'b0;
      m_level = 0;
      m_last  = '1;
      exp_vid = '0;
      exp_q.delete();
      cap_cyc.delete();
      cap_addr.delete();
      app_cyc.delete();
      app_val.delete();
    end else if (started) begin
      m_req   = m_fresh || (vid_addr != m_last);
      m_fresh = 1'b0;
      if (m_req) begin
        m_last = vid_addr;
        cap_cyc.push_back(cycle + 1);
        cap_addr.push_back(vid_addr);
      end
      exp_we = !m_req && (m_level > 0);
      if (wr_valid && m_level < FIFO_DEPTH) begin
        if (int'(wr_addr) < FB_SIZE) begin
          exp_q.push_back({wr_addr, wr_data});
          m_level++;
        end else begin
          m_oob = 1'b1;
        end
      end
      if (exp_we) m_level--;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_pix(input logic [ADDR_W-1:0] a, input logic [PIX_W-1:0] d);
    int  n = 0;
    bit  done = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    while (!done) begin
      @(negedge clk);
      done = wr_ready;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 200) begin
        checks++;
        failures++;
        $display("FAIL handshake_timeout cycle=%0d got wr_ready=0 for %0d cycles expected 1", cycle, n);
        done = 1'b1;
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic vid_step(input int period, input int count, input int base);
    for (int i = 0; i < count; i++) begin
      vid_addr = ADDR_W'(base + i);
      idle(period);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    idle(n);
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset, then idle with vid_addr=0: one read of BRAM[0] after 3 clocks.
    vid_addr = '0;
    idle(2);
    @(negedge clk);
    check("reset_ram_addr", 32'(ram_addr), 32'd0);
    check("reset_ram_wdata", 32'(ram_wdata), 32'd0);
    check("reset_wr_ready", 32'(wr_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    idle(2);
    @(negedge clk);
    check("first_read_pending", 32'(vid_data), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("first_read_data", 32'(vid_data), 32'h55);
    idle(4);

    // Five writes with wr_valid held and a static scan-out address.
    for (int i = 0; i < 5; i++) push_pix(ADDR_W'(100 + i), PIX_W'(i + 1));
    idle(10);
    for (int i = 0; i < 5; i++) check("bram_written", 32'(mem[100 + i]), 32'(i + 1));

    // Scan-out every 4 clocks while the writer streams; read back written pixels.
    fork
      vid_step(4, 12, 100);
      for (int i = 0; i < 30; i++)
        push_pix(ADDR_W'($urandom_range(96, 120)), PIX_W'($urandom));
    join
    idle(10);

    // Address changes every cycle: writes stall, FIFO fills, then drains.
    fork
      vid_step(1, 20, 500);
      for (int i = 0; i < 4; i++) push_pix(ADDR_W'(300 + i), PIX_W'($urandom));
    join
    @(negedge clk);
    check("starved_level", 32'(fifo_level), 32'd4);
    check("starved_ready", 32'(wr_ready), 32'd0);
    idle(10);

    // Out-of-range write is discarded and flagged.
    push_pix(ADDR_W'(FB_SIZE), 7'h33);
    @(negedge clk);
    check("oob_set", 32'(oob_err), 32'd1);
    push_pix(ADDR_W'(FB_SIZE - 1), 7'h44);
    idle(6);

    // Randomized traffic over a small address window so reads hit fresh writes.
    fork
      for (int i = 0; i < 80; i++) begin
        vid_addr = ADDR_W'(200 + $urandom_range(0, 15));
        idle($urandom_range(1, 6));
      end
      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        else if ($urandom_range(0, 19) == 0)
          push_pix(ADDR_W'(FB_SIZE + $urandom_range(0, 100)), PIX_W'($urandom));
        else
          push_pix(ADDR_W'(200 + $urandom_range(0, 15)), PIX_W'($urandom));
      end
    join
    idle(10);

    // Reset with three queued writes and reads in flight.
    fork
      vid_step(1, 6, 700);
      for (int i = 0; i < 3; i++) push_pix(ADDR_W'(400 + i), PIX_W'(i + 9));
    join
    @(negedge clk);
    check("pre_reset_level", 32'(fifo_level), 32'd3);
    @(posedge clk);
    #1;
    do_reset(2);
    @(negedge clk);
    check("post_reset_level", 32'(fifo_level), 32'd0);
    check("post_reset_vid", 32'(vid_data), 32'd0);
    check("post_reset_oob", 32'(oob_err), 32'd0);
    idle(8);
    for (int i = 0; i < 3; i++) check("discarded_write", 32'(mem[400 + i]), 32'(ref_mem[400 + i]));

    idle(10);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL global_timeout cycle=%0d got no finish expected finish", cycle);
    $fatal(1, "timeout");
  end

endmodule
